switch_debounce2: RTL and testbench
===================================

Name: switch_debounce2

Overview:
- Front-end conditioning stage for the two-input gate experiments.
- Takes two raw, bouncing board switches and produces the clean in1/in2 levels that drive the gate under test.
- Each channel has a 2-flop synchronizer and a stable-count debouncer, plus one-cycle edge pulses for downstream counters/LEDs.
- The two channels are identical and fully independent.

Parameters:
- DB_CYCLES, default 16: consecutive clock edges a synchronized input must disagree with the output before the output flips. Legal range is at least 2.
- CNT_W, default 5: counter width. Must satisfy 2^CNT_W > DB_CYCLES-1.

Ports:
- clk, input, 1: single system clock, rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- sw1_raw, input, 1: raw switch 1, asynchronous to clk, may bounce.
- sw2_raw, input, 1: raw switch 2, asynchronous to clk, may bounce.
- in1, output, 1: debounced level of sw1_raw; drives gate input in1.
- in2, output, 1: debounced level of sw2_raw; drives gate input in2.
- in1_rise, output, 1: one-cycle pulse when in1 goes 0->1.
- in1_fall, output, 1: one-cycle pulse when in1 goes 1->0.
- in2_rise, output, 1: one-cycle pulse when in2 goes 0->1.
- in2_fall, output, 1: one-cycle pulse when in2 goes 1->0.
- busy, output, 1: high while either channel's counter is non-zero.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - sync flops, counters, in1, in2, all pulse outputs and busy are 0.
  - Reset asserted mid-count discards the count; no pulse is emitted.
- Deassertion: the first active edge is the first rising clk edge with rst_n=1.
- Synchronizer per channel: s1 <= raw; s2 <= s1. Only s2 feeds the debouncer.
- Per channel, per rising edge (out = in1 or in2, cnt = that channel's counter):
  - s2 == out: cnt <= 0; no flip.
  - s2 != out and cnt == DB_CYCLES-1: out <= s2; cnt <= 0; pulse for that direction high for exactly this cycle.
  - s2 != out and cnt < DB_CYCLES-1: cnt <= cnt+1.
- Latency: a raw change first sampled at edge k, then held stable, appears on out after edge k+DB_CYCLES+1. The pulse is high during the cycle after that same edge.
- Bounce: any edge where s2 matches out clears cnt, so the DB_CYCLES-edge window restarts from zero.
- Glitches: a raw glitch shorter than DB_CYCLES clock periods never reaches out.
- Pulses:
  - Registered and mutually exclusive per channel; rise and fall never high together.
  - Each is high for exactly one cycle, then 0 on the next edge.
  - A pulse never coincides with a flip of the other direction on the same channel.
- Channel independence: simultaneous switching of both raw inputs flips in1 and in2 on the same edge and fires both channels' pulses together.
- busy is combinational: (cnt1 != 0) | (cnt2 != 0).
- Counter never exceeds DB_CYCLES-1; no wrap-around possible.
- Outputs in1/in2 are registered, glitch-free, and safe to feed the combinational gate directly.

Test Plan (DB_CYCLES=4):
- Reset: assert rst_n=0 with sw1_raw=sw2_raw=1 → all outputs 0 immediately and while held. Release → in1 and in2 rise 6 edges later (k = first edge after release, flip at k+5). in1_rise and in2_rise each high for exactly 1 cycle.
- Clean step: sw1_raw 0->1 before edge k, held → in1=1 after edge k+5. in1_rise high during cycle k+5..k+6. in2 and its pulses stay 0.
- Bounce: sw1_raw toggles 1,0,1,0,1 at 2-cycle intervals, then holds 1 → in1 stays 0 throughout the bounce and rises exactly 6 edges after the final 0->1. Exactly one in1_rise pulse.
- Short glitch: sw2_raw high for 3 clock periods then low → in2, in2_rise and in2_fall all remain 0. busy pulses high, then returns to 0.
- Truth-table sweep: drive (sw1,sw2) = 00, 01, 10, 11, each held for 20 cycles → in1/in2 follow each pair with 6-edge latency. Combined with the downstream gate, out follows the gate's truth table for every pair.
- Reset mid-count: sw1_raw 0->1, assert rst_n at the 3rd edge → in1 stays 0 and no pulse. After release with sw1_raw=1, in1 rises 6 edges later.

Source files
------------

// File: rtl/switch_debounce2.sv
// switch_debounce2 - two-channel switch conditioning front end.
//
// Each raw switch passes through a 2-flop synchronizer and a stable-count
// debouncer; the debounced level flips only after the synchronized input has
// disagreed with it on DB_CYCLES consecutive rising edges. A registered
// one-cycle pulse marks each flip direction.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   sw1_raw   - raw switch 1 (asynchronous, bouncing)
//   sw2_raw   - raw switch 2 (asynchronous, bouncing)
//   in1, in2  - debounced, registered switch levels
//   in1_rise, in1_fall, in2_rise, in2_fall - one-cycle flip pulses
//   busy      - high while either debounce counter is non-zero
module switch_debounce2 #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw1_raw,
  input  logic sw2_raw,
  output logic in1,
  output logic in2,
  output logic in1_rise,
  output logic in1_fall,
  output logic in2_rise,
  output logic in2_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Bit 0 is channel 1, bit 1 is channel 2.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       lvl;
  logic [1:0]       rise;
  logic [1:0]       fall;
  logic [CNT_W-1:0] cnt [2];

  assign raw = {sw2_raw, sw1_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      lvl  <= '0;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2[i] == lvl[i]) begin
          // Any agreement restarts the stability window.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          lvl[i]  <= s2[i];
          cnt[i]  <= '0;
          rise[i] <= s2[i];
          fall[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign in1      = lvl[0];
  assign in2      = lvl[1];
  assign in1_rise = rise[0];
  assign in1_fall = fall[0];
  assign in2_rise = rise[1];
  assign in2_fall = fall[1];
  assign busy     = (cnt[0] != '0) | (cnt[1] != '0);

endmodule

// File: tb/tb_switch_debounce2.sv
module tb_switch_debounce2;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sw1_raw, sw2_raw;
  logic in1, in2, in1_rise, in1_fall, in2_rise, in2_fall, busy;

  int n_cmp = 0;
  int n_bad = 0;

  switch_debounce2 #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw1_raw(sw1_raw), .sw2_raw(sw2_raw),
    .in1(in1), .in2(in2), .in1_rise(in1_rise), .in1_fall(in1_fall),
    .in2_rise(in2_rise), .in2_fall(in2_fall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronized value seen at edge n is the raw value
  // sampled two edges earlier (0 for the first two edges after reset). The
  // level flips when the last DB synchronized values since reset all differ
  // from the current level; a counter is non-zero exactly when the latest
  // edge disagreed without flipping.
  bit m_out  [2];
  bit m_rise [2];
  bit m_fall [2];
  bit m_busy [2];
  bit smp    [2][$];
  bit used   [2][$];

  always @(posedge clk or negedge rst_n) begin : model
    bit r, s2v, flip;
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_out[ch] = 0; m_rise[ch] = 0; m_fall[ch] = 0; m_busy[ch] = 0;
        smp[ch].delete();
        used[ch].delete();
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        r   = (ch == 0) ? sw1_raw : sw2_raw;
        s2v = (smp[ch].size() >= 2) ? smp[ch][smp[ch].size()-2] : 1'b0;
        used[ch].push_back(s2v);
        if (used[ch].size() > DB) void'(used[ch].pop_front());
        flip = (used[ch].size() == DB);
        foreach (used[ch][j]) if (used[ch][j] == m_out[ch]) flip = 0;
        m_rise[ch] = flip && s2v;
        m_fall[ch] = flip && !s2v;
        m_busy[ch] = !flip && (s2v != m_out[ch]);
        if (flip) m_out[ch] = s2v;
        smp[ch].push_back(r);
        if (smp[ch].size() > 2) void'(smp[ch].pop_front());
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in1",      in1,      m_out[0]);
    chk("in2",      in2,      m_out[1]);
    chk("in1_rise", in1_rise, m_rise[0]);
    chk("in1_fall", in1_fall, m_fall[0]);
    chk("in2_rise", in2_rise, m_rise[1]);
    chk("in2_fall", in2_fall, m_fall[1]);
    chk("busy",     busy,     m_busy[0] | m_busy[1]);
  end

  int r1 = 0, r2 = 0;
  always @(negedge clk) begin
    r1 += int'(in1_rise);
    r2 += int'(in2_rise);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edges from the current point until the channel reaches lvl; -1 on timeout.
  task automatic edges_until(input int ch, input bit lvl, output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (((ch == 0) ? in1 : in2) == lvl) return;
    end
    n = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, base1, base2;
    bit busy_seen, in2_any;
    int left [2];
    bit bouncy [2];
    bit val [2];

    // Reset with both switches closed.
    rst_n = 1'b0; sw1_raw = 1'b1; sw2_raw = 1'b1;
    #3;
    chk("reset_imm_in1", in1, 0);
    chk("reset_imm_busy", busy, 0);
    step(3);
    rst_n = 1'b1;
    edges_until(0, 1'b1, n);
    chk("reset_release_latency", n, 6);
    chk("reset_release_in2", in2, 1);
    chk("reset_release_in1_rise", in1_rise, 1);
    step(3);
    chk("reset_release_rise1_count", r1, 1);
    chk("reset_release_rise2_count", r2, 1);

    // Clean step on switch 1.
    sw1_raw = 1'b0; sw2_raw = 1'b0;
    step(20);
    base2 = r2;
    sw1_raw = 1'b1;
    edges_until(0, 1'b1, n);
    chk("clean_step_latency", n, 6);
    chk("clean_step_rise_now", in1_rise, 1);
    @(posedge clk); #1;
    chk("clean_step_rise_next", in1_rise, 0);
    chk("clean_step_in2", in2, 0);
    step(5);
    chk("clean_step_no_in2_rise", r2 - base2, 0);

    // Bouncing closure on switch 1.
    sw1_raw = 1'b0;
    step(20);
    base1 = r1;
    sw1_raw = 1'b1; step(2);
    sw1_raw = 1'b0; step(2);
    sw1_raw = 1'b1; step(2);
    sw1_raw = 1'b0; step(2);
    chk("bounce_in1_low", in1, 0);
    sw1_raw = 1'b1;
    edges_until(0, 1'b1, n);
    chk("bounce_latency", n, 6);
    step(10);
    chk("bounce_one_rise", r1 - base1, 1);

    // Short glitch on switch 2.
    busy_seen = 0; in2_any = 0;
    sw2_raw = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) sw2_raw = 1'b0;
      @(negedge clk);
      busy_seen |= busy;
      in2_any   |= in2 | in2_rise | in2_fall;
    end
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_in2_quiet", in2_any, 0);
    chk("glitch_busy_clear", busy, 0);

    // Truth-table sweep; the downstream gate is modelled as AND.
    for (int p = 0; p < 4; p++) begin
      sw1_raw = p[1]; sw2_raw = p[0];
      step(20);
      chk("sweep_in1", in1, p[1]);
      chk("sweep_in2", in2, p[0]);
      chk("sweep_gate", in1 & in2, p[1] & p[0]);
    end

    // Reset arriving mid-count.
    sw1_raw = 1'b0; sw2_raw = 1'b0;
    step(20);
    sw1_raw = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_in1", in1, 0);
    chk("midreset_busy", busy, 0);
    base1 = r1;
    step(3);
    rst_n = 1'b1;
    edges_until(0, 1'b1, n);
    chk("midreset_release_latency", n, 6);
    step(3);
    chk("midreset_one_rise", r1 - base1, 1);

    // Randomized bouncing segments with occasional resets.
    left[0] = 0; left[1] = 0; bouncy[0] = 0; bouncy[1] = 0;
    val[0] = sw1_raw; val[1] = sw2_raw;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (left[ch] == 0) begin
          left[ch]   = $urandom_range(1, 12);
          bouncy[ch] = ($urandom_range(0, 2) == 0);
          val[ch]    = 1'($urandom_range(0, 1));
        end
        left[ch]--;
        if (bouncy[ch]) val[ch] = 1'($urandom_range(0, 1));
      end
      sw1_raw = val[0];
      sw2_raw = val[1];
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
